helper_axis_drainer: RTL and testbench

Test-bench AXIS sink that terminates a stream under test, driving `input_ready` with a reproducible pseudo-random stall pattern while passive inline checkers tap the same valid/data/ready triple. It counts accepted transactions, flags completion after a programmed count, and raises a watchdog error when the stream stalls too long. It is the consumer half of every DUT output port in the block-level benches.

---
 rtl/helper_axis_pkg.sv | 20 ++
 rtl/helper_lfsr16.sv | 24 ++
 rtl/helper_axis_drainer.sv | 116 +++++++++++
 tb/tb_helper_axis_drainer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/helper_axis_pkg.sv
// Shared types and constants for the AXIS drainer helper: FSM state encoding
// and the 16-bit Galois LFSR that paces the stall pattern.
package helper_axis_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } drain_state_t;

  localparam logic [15:0] LFSR16_MASK         = 16'hB400;
  localparam logic [15:0] LFSR16_DEFAULT_SEED = 16'hACE1;

  // One right-shifting Galois step; the feedback taps fold in when bit 0 falls out.
  function automatic logic [15:0] lfsr16_step(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR16_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/helper_lfsr16.sv
// 16-bit Galois LFSR that steps only when advance is high; a zero seed is
// swapped for the default so the register can never lock up.
module helper_lfsr16
  import helper_axis_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR16_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] state
);

  localparam logic [15:0] EFF_SEED = (SEED == 16'h0000) ? LFSR16_DEFAULT_SEED : SEED;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EFF_SEED;
    end else if (advance) begin
      state <= lfsr16_step(state);
    end
  end

endmodule

// File: rtl/helper_axis_drainer.sv
// AXIS sink with pseudo-random ready stalls, transaction counter, completion flag
// and stall watchdog. Define HELPER_AXIS_DRAINER_LOG_EN for $info tracing.
//
// Handshake: a beat transfers on a rising edge where input_valid && input_ready;
// input_ready depends only on registered state, never on input_valid or enable,
// and the source is free to hold or change data while ready is low.
module helper_axis_drainer
  import helper_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 10,
  parameter int unsigned EXPECTED_COUNT  = 0,
  parameter int unsigned STALL_THRESHOLD = 0,
  parameter logic [15:0] STALL_SEED      = 16'hACE1,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  input_valid,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  input_ready,
  output logic [31:0]           count,
  output logic [DATA_WIDTH-1:0] last_data,
  output logic                  done,
  output logic                  timeout_err,
  output drain_state_t          state_dbg
);

  localparam logic [7:0]  STALL_TH = 8'(STALL_THRESHOLD);
  localparam logic [31:0] EXP_CNT  = 32'(EXPECTED_COUNT);
  localparam logic [31:0] TO_CYC   = 32'(TIMEOUT_CYCLES);

  drain_state_t state_q, state_d;
  logic [15:0]  lfsr;
  logic [31:0]  stall_q, stall_d;
  logic         running;
  logic         handshake;
  logic         completes;
  logic         stall_hit;

  assign running = (state_q == RUN);

  helper_lfsr16 #(
    .SEED (STALL_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (running),
    .state   (lfsr)
  );

  assign input_ready = running && (lfsr[7:0] >= STALL_TH);
  assign handshake   = input_valid && input_ready;
  assign completes   = handshake && (EXP_CNT != 32'd0) && ((count + 32'd1) == EXP_CNT);

  // Stall counter value after this edge: any idle RUN cycle counts, ready low or not.
  always_comb begin
    stall_d = stall_q;
    if (!running || handshake) begin
      stall_d = '0;
    end else if (stall_q < TO_CYC) begin
      stall_d = stall_q + 32'd1;
    end
  end

  assign stall_hit = (TO_CYC != 32'd0) && running && !handshake && (stall_d == TO_CYC);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        // A completing beat outranks both the watchdog and a pause request.
        if (completes) state_d = DONE;
        else if (stall_hit) state_d = TIMEOUT;
        else if (!enable) state_d = IDLE;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      stall_q   <= '0;
      count     <= '0;
      last_data <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      if (handshake) begin
        count     <= count + 32'd1;
        last_data <= input_data;
      end
    end
  end

  assign done        = (state_q == DONE);
  assign timeout_err = (state_q == TIMEOUT);
  assign state_dbg   = state_q;

`ifdef HELPER_AXIS_DRAINER_LOG_EN
  always @(posedge clk) begin
    if (rst) begin
      if (handshake) $info("drainer handshake count=%0d data=%0h", count + 32'd1, input_data);
      if (running && state_d == DONE) $info("drainer done after %0d beats", count + 32'd1);
      if (running && state_d == TIMEOUT) $info("drainer timeout after %0d stall cycles", stall_d);
    end
  end
`else
  // Silent build: no trace messages.
`endif

endmodule

// File: tb/tb_helper_axis_drainer.sv
// Bench for helper_axis_drainer: directed checks on completion, watchdog and
// done/timeout tie, plus a randomized stall-pattern run against a reference model.
module tb_helper_axis_drainer;
  import helper_axis_pkg::*;

  localparam int W = 10;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic b_rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: EXPECTED_COUNT=8, no stalls ----------------
  logic a_en = 0, a_valid = 0, a_ready, a_done, a_err;
  logic [W-1:0] a_data = '0, a_last;
  logic [31:0] a_count;
  drain_state_t a_st;
  helper_axis_drainer #(.DATA_WIDTH(W), .EXPECTED_COUNT(8), .STALL_THRESHOLD(0),
                        .STALL_SEED(16'hACE1), .TIMEOUT_CYCLES(0)) u_a (
    .clk(clk), .rst(rst), .enable(a_en), .input_valid(a_valid), .input_data(a_data),
    .input_ready(a_ready), .count(a_count), .last_data(a_last), .done(a_done),
    .timeout_err(a_err), .state_dbg(a_st));

  // ---------------- instance B: random stalls, threshold 128 ----------------
  logic b_en = 0, b_valid = 0, b_ready, b_done, b_err;
  logic [W-1:0] b_data = '0, b_last;
  logic [31:0] b_count;
  drain_state_t b_st;
  helper_axis_drainer #(.DATA_WIDTH(W), .EXPECTED_COUNT(0), .STALL_THRESHOLD(128),
                        .STALL_SEED(16'hACE1), .TIMEOUT_CYCLES(0)) u_b (
    .clk(clk), .rst(b_rst), .enable(b_en), .input_valid(b_valid), .input_data(b_data),
    .input_ready(b_ready), .count(b_count), .last_data(b_last), .done(b_done),
    .timeout_err(b_err), .state_dbg(b_st));

  // ---------------- instance C: watchdog 16 ----------------
  logic c_en = 0, c_valid = 0, c_ready, c_done, c_err;
  logic [W-1:0] c_data = '0, c_last;
  logic [31:0] c_count;
  drain_state_t c_st;
  helper_axis_drainer #(.DATA_WIDTH(W), .EXPECTED_COUNT(0), .STALL_THRESHOLD(0),
                        .STALL_SEED(16'hACE1), .TIMEOUT_CYCLES(16)) u_c (
    .clk(clk), .rst(rst), .enable(c_en), .input_valid(c_valid), .input_data(c_data),
    .input_ready(c_ready), .count(c_count), .last_data(c_last), .done(c_done),
    .timeout_err(c_err), .state_dbg(c_st));

  // ---------------- instance D: done/timeout tie ----------------
  logic d_en = 0, d_valid = 0, d_ready, d_done, d_err;
  logic [W-1:0] d_data = '0, d_last;
  logic [31:0] d_count;
  drain_state_t d_st;
  helper_axis_drainer #(.DATA_WIDTH(W), .EXPECTED_COUNT(4), .STALL_THRESHOLD(0),
                        .STALL_SEED(16'hACE1), .TIMEOUT_CYCLES(4)) u_d (
    .clk(clk), .rst(rst), .enable(d_en), .input_valid(d_valid), .input_data(d_data),
    .input_ready(d_ready), .count(d_count), .last_data(d_last), .done(d_done),
    .timeout_err(d_err), .state_dbg(d_st));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model for instance B ----------------
  logic [15:0] m_lfsr = 16'hACE1;
  logic        m_run  = 1'b0;
  logic [31:0] m_count = '0;

  function automatic logic [15:0] ref_lfsr_next(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // ---------------- scoreboard queues ----------------
  logic [W-1:0] exp_q[$];
  logic [31:0]  exp_cnt_q[$];
  logic         rdy_q[$];

  // Called at posedge+2: drives one cycle of stimulus and records what the
  // model says must happen at the coming edge.
  task automatic b_cycle(input logic en, input logic v, input logic [W-1:0] d);
    logic exp_rdy;
    b_en = en;
    b_valid = v;
    b_data = d;
    exp_rdy = m_run && ((m_lfsr & 16'h00FF) >= 16'd128);
    rdy_q.push_back(exp_rdy);
    if (v && exp_rdy) begin
      m_count = m_count + 32'd1;
      exp_q.push_back(d);
      exp_cnt_q.push_back(m_count);
    end
    if (m_run) m_lfsr = ref_lfsr_next(m_lfsr);
    m_run = en;
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor for instance B ----------------
  logic b_pend = 1'b0;
  always @(negedge clk) begin
    if (!b_rst) begin
      b_pend = 1'b0;
    end else begin
      if (b_pend) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL b_unexpected_hs: got count %0h, expected no handshake", b_count);
        end else begin
          chk("b_last_data", 32'(b_last), 32'(exp_q.pop_front()));
          chk("b_count", b_count, exp_cnt_q.pop_front());
        end
        b_pend = 1'b0;
      end
      if (rdy_q.size() != 0) begin
        chk("b_ready", 32'(b_ready), 32'(rdy_q.pop_front()));
        if (b_valid && b_ready) b_pend = 1'b1;
      end
    end
  end

  // ---------------- global time bound ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time bound expired, got no finish, expected finish");
    $fatal(1, "time bound expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;
    #1;
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_a_last", 32'(a_last), 0);
    chk("rst_a_done", 32'(a_done), 0);
    chk("rst_a_err", 32'(a_err), 0);
    chk("rst_b_state", 32'(b_st), 32'(IDLE));
    @(posedge clk);
    #2;
    rst = 1'b1;
    b_rst = 1'b1;

    // A: eight beats 0..7 complete the stream.
    a_en = 1'b1; a_valid = 1'b1; a_data = '0;
    @(posedge clk); #2;
    for (int i = 0; i < 8; i++) begin
      chk("a_ready_run", 32'(a_ready), 1);
      chk("a_done_early", 32'(a_done), 0);
      @(posedge clk); #2;
      chk("a_count", a_count, 32'(i + 1));
      chk("a_last", 32'(a_last), 32'(i));
      a_data = W'(i + 1);
    end
    chk("a_done", 32'(a_done), 1);
    chk("a_ready_after_done", 32'(a_ready), 0);
    repeat (3) @(posedge clk);
    #2;
    chk("a_count_frozen", a_count, 8);
    chk("a_done_sticky", 32'(a_done), 1);
    a_en = 1'b0; a_valid = 1'b0;

    // C: watchdog fires after exactly 16 RUN cycles.
    c_en = 1'b1;
    @(posedge clk); #2;
    repeat (15) @(posedge clk);
    #2;
    chk("c_err_before", 32'(c_err), 0);
    chk("c_ready_before", 32'(c_ready), 1);
    @(posedge clk); #2;
    chk("c_err", 32'(c_err), 1);
    chk("c_ready_after", 32'(c_ready), 0);
    chk("c_done", 32'(c_done), 0);
    c_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("c_err_sticky", 32'(c_err), 1);

    // D: 4th beat lands when the stall counter would reach 4.
    d_en = 1'b1;
    @(posedge clk); #2;
    d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_data = W'($urandom);
      @(posedge clk); #2;
    end
    chk("d_count3", d_count, 3);
    d_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("d_done_pre", 32'(d_done), 0);
    chk("d_err_pre", 32'(d_err), 0);
    d_valid = 1'b1;
    d_data = W'($urandom);
    @(posedge clk); #2;
    chk("d_done_tie", 32'(d_done), 1);
    chk("d_err_tie", 32'(d_err), 0);
    chk("d_count4", d_count, 4);
    d_valid = 1'b0; d_en = 1'b0;

    // B: run until three beats accepted, then pulse reset mid-stream.
    k = 0;
    while (m_count < 32'd3 && k < 300) begin
      b_cycle(1'b1, 1'($urandom_range(0, 1)), W'($urandom));
      k++;
    end
    b_cycle(1'b1, 1'b0, '0);
    chk("b_count_pre_rst", b_count, 3);
    b_rst = 1'b0;
    #1;
    chk("b_rst_ready", 32'(b_ready), 0);
    chk("b_rst_count", b_count, 0);
    chk("b_rst_last", 32'(b_last), 0);
    chk("b_rst_done", 32'(b_done), 0);
    chk("b_rst_err", 32'(b_err), 0);
    chk("b_rst_state", 32'(b_st), 32'(IDLE));
    @(posedge clk); #2;
    b_rst = 1'b1;
    m_lfsr = 16'hACE1; m_run = 1'b0; m_count = '0;
    exp_q.delete(); exp_cnt_q.delete(); rdy_q.delete();

    // Always-valid stall pattern with a five-cycle pause, then random traffic.
    for (int i = 0; i < 1000; i++) begin
      b_cycle(!(i >= 400 && i < 405), 1'b1, W'($urandom));
    end
    for (int i = 0; i < 200; i++) begin
      b_cycle($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), W'($urandom));
    end
    b_cycle(1'b0, 1'b0, '0);
    b_cycle(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    chk("b_exp_q_empty", exp_q.size(), 0);
    chk("b_rdy_q_empty", rdy_q.size(), 0);
    chk("b_count_final", b_count, m_count);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
